// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : alu_multicycle
// Description : Registered ALU with a start/busy/done handshake and full
//               status flags. Multiply and divide are iterative and take one
//               bit per cycle; all other operations complete on the edge that
//               accepts them.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   In_CLK         rising-edge clock
//   In_Reset       asynchronous active-high reset
//   In_Start       request, accepted only while Out_Busy is low
//   In_A, In_B     operands (two's complement); In_B is also the shift amount
//   In_ALUCtrl     4-bit operation select
//   Out_ALUResult  registered result, held until the next completion
//   Out_Zero / Out_Negative / Out_Carry / Out_Overflow / Out_DivByZero
//                  status flags, updated only at completion
//   Out_Busy       an iterative multiply/divide is in progress
//   Out_Done       one-cycle pulse following every completion
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input  logic             In_CLK,
    input  logic             In_Reset,
    input  logic             In_Start,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    input  logic [3:0]       In_ALUCtrl,
    output logic [WIDTH-1:0] Out_ALUResult,
    output logic             Out_Zero,
    output logic             Out_Negative,
    output logic             Out_Carry,
    output logic             Out_Overflow,
    output logic             Out_DivByZero,
    output logic             Out_Busy,
    output logic             Out_Done
);

    localparam int c_SW = $clog2(WIDTH);
    localparam int c_CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] c_WIDTH_VAL  = WIDTH'(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST_ITER  = c_CW'(WIDTH - 1);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_SLL  = 4'b0101;
    localparam logic [3:0] c_OP_SRL  = 4'b0110;
    localparam logic [3:0] c_OP_NOT  = 4'b0111;
    localparam logic [3:0] c_OP_MUL  = 4'b1000;
    localparam logic [3:0] c_OP_DIV  = 4'b1001;
    localparam logic [3:0] c_OP_INC  = 4'b1010;
    localparam logic [3:0] c_OP_DEC  = 4'b1011;
    localparam logic [3:0] c_OP_SLA  = 4'b1100;
    localparam logic [3:0] c_OP_SRA  = 4'b1101;
    localparam logic [3:0] c_OP_PASS = 4'b1110;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_neg;
    logic               r_carry;
    logic               r_ovf;
    logic               r_dbz;
    logic               r_done;

    logic [c_CW-1:0]    r_cnt;
    logic               r_res_neg;      // sign to apply to the magnitude result
    logic [2*WIDTH-1:0] r_mcand;        // multiplicand, shifted left each step
    logic [WIDTH-1:0]   r_mplier;       // multiplier, shifted right each step
    logic [2*WIDTH-1:0] r_prod;         // partial product magnitude
    logic [WIDTH-1:0]   r_rem;          // partial remainder
    logic [WIDTH-1:0]   r_quot;         // dividend bits in, quotient bits out
    logic [WIDTH-1:0]   r_divisor;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic w_accept;
    logic w_start_mul;
    logic w_start_div;
    logic w_b_zero;
    logic w_last_iter;
    logic w_complete;

    assign w_b_zero    = (In_B == '0);
    assign w_accept    = In_Start && (r_state == c_ST_IDLE);
    assign w_start_mul = w_accept && (In_ALUCtrl == c_OP_MUL);
    assign w_start_div = w_accept && (In_ALUCtrl == c_OP_DIV) && !w_b_zero;
    assign w_last_iter = (r_cnt == c_LAST_ITER);

    // Divide-by-zero never enters the iterative state; it completes like any
    // single-cycle operation.
    assign w_complete  = (w_accept && !w_start_mul && !w_start_div) ||
                         (((r_state == c_ST_MUL) || (r_state == c_ST_DIV)) && w_last_iter);

    // ------------------------------------------------------------------------
    // Operand magnitudes for multiply / divide
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    // The most-negative value maps onto itself, which read as unsigned is
    // exactly its magnitude.
    assign w_abs_a = In_A[WIDTH-1] ? -In_A : In_A;
    assign w_abs_b = In_B[WIDTH-1] ? -In_B : In_B;

    // ------------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------------
    logic [c_SW-1:0]  w_shamt;
    logic             w_shift_oor;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_sla_back;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_sc_result;
    logic             w_sc_carry;
    logic             w_sc_ovf;
    logic             w_sc_dbz;

    assign w_shamt     = In_B[c_SW-1:0];
    assign w_shift_oor = (In_B >= c_WIDTH_VAL);
    assign w_sll       = w_shift_oor ? '0 : (In_A << w_shamt);
    assign w_srl       = w_shift_oor ? '0 : (In_A >> w_shamt);
    assign w_sra       = w_shift_oor ? {WIDTH{In_A[WIDTH-1]}}
                                     : WIDTH'($signed(In_A) >>> w_shamt);
    assign w_sla_back  = WIDTH'($signed(w_sll) >>> w_shamt);

    always_comb begin
        w_sum       = '0;
        w_sc_result = '0;
        w_sc_carry  = 1'b0;
        w_sc_ovf    = 1'b0;
        w_sc_dbz    = 1'b0;
        case (In_ALUCtrl)
            c_OP_ADD: begin
                w_sum       = {1'b0, In_A} + {1'b0, In_B};
                w_sc_result = w_sum[WIDTH-1:0];
                w_sc_carry  = w_sum[WIDTH];
                w_sc_ovf    = (In_A[WIDTH-1] == In_B[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != In_A[WIDTH-1]);
            end
            c_OP_SUB: begin
                // A + ~B + 1: the carry-out is the inverse of the borrow
                w_sum       = {1'b0, In_A} + {1'b0, ~In_B} + {{WIDTH{1'b0}}, 1'b1};
                w_sc_result = w_sum[WIDTH-1:0];
                w_sc_carry  = w_sum[WIDTH];
                w_sc_ovf    = (In_A[WIDTH-1] != In_B[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != In_A[WIDTH-1]);
            end
            c_OP_AND:  w_sc_result = In_A & In_B;
            c_OP_OR:   w_sc_result = In_A | In_B;
            c_OP_XOR:  w_sc_result = In_A ^ In_B;
            c_OP_SLL:  w_sc_result = w_sll;
            c_OP_SRL:  w_sc_result = w_srl;
            c_OP_NOT:  w_sc_result = ~In_A;
            c_OP_DIV: begin
                // Only reaches completion here when B is zero
                w_sc_result = '0;
                w_sc_dbz    = 1'b1;
            end
            c_OP_INC: begin
                w_sum       = {1'b0, In_A} + {{WIDTH{1'b0}}, 1'b1};
                w_sc_result = w_sum[WIDTH-1:0];
                w_sc_carry  = w_sum[WIDTH];
                w_sc_ovf    = !In_A[WIDTH-1] && w_sum[WIDTH-1];
            end
            c_OP_DEC: begin
                // A + all-ones: carry-out set unless A was zero (no borrow)
                w_sum       = {1'b0, In_A} + {1'b0, {WIDTH{1'b1}}};
                w_sc_result = w_sum[WIDTH-1:0];
                w_sc_carry  = w_sum[WIDTH];
                w_sc_ovf    = In_A[WIDTH-1] && !w_sum[WIDTH-1];
            end
            c_OP_SLA: begin
                w_sc_result = w_sll;
                // Out of range the result is 0, which only loses information
                // when A was non-zero.
                w_sc_ovf    = w_shift_oor ? (|In_A) : (w_sla_back != In_A);
            end
            c_OP_SRA:  w_sc_result = w_sra;
            c_OP_PASS: w_sc_result = In_B;
            default:   w_sc_result = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Iterative multiply (shift-add on magnitudes)
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_next;
    logic [2*WIDTH-1:0] w_prod_signed;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mul_ovf;

    assign w_prod_next   = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_signed = r_res_neg ? -w_prod_next : w_prod_next;
    // The low half is representable only if every bit from the result MSB
    // upward is a copy of that sign bit.
    assign w_prod_hi     = w_prod_signed[2*WIDTH-1:WIDTH-1];
    assign w_mul_ovf     = !((&w_prod_hi) || !(|w_prod_hi));

    // ------------------------------------------------------------------------
    // Iterative divide (restoring, on magnitudes)
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_rem_sh;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_quot_signed;
    logic             w_div_ovf;

    assign w_rem_sh      = {r_rem, r_quot[WIDTH-1]};
    // The remainder always stays below the divisor, so a W-bit subtraction
    // suffices once the shifted-out bit is folded into the compare.
    assign w_div_ge      = w_rem_sh[WIDTH] || (w_rem_sh[WIDTH-1:0] >= r_divisor);
    assign w_rem_next    = w_div_ge ? (w_rem_sh[WIDTH-1:0] - r_divisor) : w_rem_sh[WIDTH-1:0];
    assign w_quot_next   = {r_quot[WIDTH-2:0], w_div_ge};
    assign w_quot_signed = r_res_neg ? -w_quot_next : w_quot_next;
    // A positive quotient with the MSB set only arises from MIN / -1
    assign w_div_ovf     = !r_res_neg && w_quot_next[WIDTH-1];

    // ------------------------------------------------------------------------
    // Completion value select
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_fin_result;
    logic             w_fin_carry;
    logic             w_fin_ovf;
    logic             w_fin_dbz;

    always_comb begin
        w_fin_result = w_sc_result;
        w_fin_carry  = w_sc_carry;
        w_fin_ovf    = w_sc_ovf;
        w_fin_dbz    = w_sc_dbz;
        if (r_state == c_ST_MUL) begin
            w_fin_result = w_prod_signed[WIDTH-1:0];
            w_fin_carry  = 1'b0;
            w_fin_ovf    = w_mul_ovf;
            w_fin_dbz    = 1'b0;
        end else if (r_state == c_ST_DIV) begin
            w_fin_result = w_quot_signed;
            w_fin_carry  = 1'b0;
            w_fin_ovf    = w_div_ovf;
            w_fin_dbz    = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge In_CLK or posedge In_Reset) begin
        if (In_Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_mul) begin
                    w_state_next = c_ST_MUL;
                end else if (w_start_div) begin
                    w_state_next = c_ST_DIV;
                end
            end
            c_ST_MUL, c_ST_DIV: begin
                if (w_last_iter) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge In_CLK or posedge In_Reset) begin
        if (In_Reset) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_res_neg <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else begin
            r_done <= w_complete;

            if (w_complete) begin
                r_result <= w_fin_result;
                r_zero   <= (w_fin_result == '0);
                r_neg    <= w_fin_result[WIDTH-1];
                r_carry  <= w_fin_carry;
                r_ovf    <= w_fin_ovf;
                r_dbz    <= w_fin_dbz;
            end

            if (w_start_mul || w_start_div) begin
                r_cnt     <= '0;
                r_res_neg <= In_A[WIDTH-1] ^ In_B[WIDTH-1];
                r_mcand   <= {{WIDTH{1'b0}}, w_abs_a};
                r_mplier  <= w_abs_b;
                r_prod    <= '0;
                r_rem     <= '0;
                r_quot    <= w_abs_a;
                r_divisor <= w_abs_b;
            end else if (r_state == c_ST_MUL) begin
                r_cnt    <= r_cnt + 1'b1;
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end else if (r_state == c_ST_DIV) begin
                r_cnt  <= r_cnt + 1'b1;
                r_rem  <= w_rem_next;
                r_quot <= w_quot_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Out_ALUResult = r_result;
    assign Out_Zero      = r_zero;
    assign Out_Negative  = r_neg;
    assign Out_Carry     = r_carry;
    assign Out_Overflow  = r_ovf;
    assign Out_DivByZero = r_dbz;
    assign Out_Busy      = (r_state != c_ST_IDLE);
    assign Out_Done      = r_done;

endmodule
`default_nettype wire
